micro_instruction_decoder: RTL and testbench

- Microcode control decoder for the 4-bit accumulator CPU.
- Maps the current 4-bit opcode and the current one-hot machine phase (T0..T3) to 11 one-hot-style control strobes that drive the PC, memory, instruction register, A/B registers, ALU, input port and output port.
- Sits between the instruction register / phase generator and the datapath.
- Outputs are registered on the single clock.

---
 rtl/micro_instr_pkg.sv | 33 +++
 rtl/micro_instr_rom.sv | 42 ++++
 rtl/micro_instruction_decoder.sv | 73 +++++++
 tb/tb_micro_instruction_decoder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/micro_instr_pkg.sv
// Shared opcode/phase constants and the control-word layout for micro_instruction_decoder.
package micro_instr_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_OUT  = 4'b0011;
    localparam logic [3:0] OP_IN   = 4'b0100;
    localparam logic [3:0] OP_LOAD = 4'b0101;

    localparam int unsigned PH_T0 = 0;
    localparam int unsigned PH_T1 = 1;
    localparam int unsigned PH_T2 = 2;
    localparam int unsigned PH_T3 = 3;

    // Field order matches the top-level output port order.
    typedef struct packed {
        logic prog_count;
        logic load_out;
        logic add_sub;
        logic enable_in;
        logic enable_alu;
        logic read_mem;
        logic load_b;
        logic load_instr;
        logic enable_a;
        logic enable_instr;
        logic load_a;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/micro_instr_rom.sv
// Combinational (opcode, one-hot phase) -> control word lookup with illegal-decode flag.
module micro_instr_rom
    import micro_instr_pkg::*;
(
    input  logic [3:0]  instr,
    input  logic [3:0]  phase,
    output ctrl_word_t  ctrl,
    output logic        illegal
);

    always_comb begin
        ctrl    = CTRL_IDLE;
        illegal = 1'b0;
        if (!$onehot(phase)) begin
            illegal = 1'b1;
        end else if (phase[PH_T0]) begin
            ctrl.read_mem   = 1'b1;
            ctrl.load_instr = 1'b1;
        end else if (phase[PH_T1]) begin
            ctrl.prog_count   = 1'b1;
            ctrl.enable_instr = 1'b1;
        end else if (phase[PH_T2]) begin
            case (instr)
                OP_NOP:  ctrl.read_mem = 1'b1;
                OP_ADD:  begin ctrl.load_b = 1'b1; ctrl.enable_instr = 1'b1; end
                OP_SUB:  begin ctrl.add_sub = 1'b1; ctrl.load_b = 1'b1; ctrl.enable_instr = 1'b1; end
                OP_OUT:  begin ctrl.load_out = 1'b1; ctrl.enable_a = 1'b1; end
                OP_IN:   begin ctrl.enable_in = 1'b1; ctrl.load_a = 1'b1; end
                OP_LOAD: begin ctrl.enable_instr = 1'b1; ctrl.load_a = 1'b1; end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (instr)
                OP_ADD:  begin ctrl.enable_alu = 1'b1; ctrl.load_a = 1'b1; end
                OP_SUB:  begin ctrl.enable_alu = 1'b1; ctrl.add_sub = 1'b1; ctrl.load_a = 1'b1; end
                OP_NOP, OP_OUT, OP_IN, OP_LOAD: ctrl = CTRL_IDLE;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/micro_instruction_decoder.sv
// Registered microcode control decoder for the 4-bit accumulator CPU.
// Optional MICRO_INSTR_PHASE_GEN_EN replaces the phase port with an internal one-hot ring counter.
module micro_instruction_decoder
    import micro_instr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] instr,
    input  logic [3:0] phase,
    output logic       prog_count,
    output logic       load_out,
    output logic       add_sub,
    output logic       enable_in,
    output logic       enable_alu,
    output logic       read_mem,
    output logic       load_b,
    output logic       load_instr,
    output logic       enable_a,
    output logic       enable_instr,
    output logic       load_a,
    output logic       illegal
);

    logic [3:0] phase_sel;
    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;
    logic       illegal_d;
    logic       illegal_q;

`ifdef MICRO_INSTR_PHASE_GEN_EN
    logic [3:0] ring;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ring <= 4'b0001;
        else     ring <= {ring[2:0], ring[3]};
    end

    assign phase_sel = ring;
`else
    assign phase_sel = phase;
`endif

    micro_instr_rom u_rom (
        .instr   (instr),
        .phase   (phase_sel),
        .ctrl    (ctrl_d),
        .illegal (illegal_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= CTRL_IDLE;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign prog_count   = ctrl_q.prog_count;
    assign load_out     = ctrl_q.load_out;
    assign add_sub      = ctrl_q.add_sub;
    assign enable_in    = ctrl_q.enable_in;
    assign enable_alu   = ctrl_q.enable_alu;
    assign read_mem     = ctrl_q.read_mem;
    assign load_b       = ctrl_q.load_b;
    assign load_instr   = ctrl_q.load_instr;
    assign enable_a     = ctrl_q.enable_a;
    assign enable_instr = ctrl_q.enable_instr;
    assign load_a       = ctrl_q.load_a;
    assign illegal      = illegal_q;

endmodule

// File: tb/tb_micro_instruction_decoder.sv
// Self-checking bench for micro_instruction_decoder; ring-counter path covered when MICRO_INSTR_PHASE_GEN_EN is defined.
module tb_micro_instruction_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] instr = '0;
    logic [3:0] phase = '0;
    logic prog_count, load_out, add_sub, enable_in, enable_alu, read_mem;
    logic load_b, load_instr, enable_a, enable_instr, load_a, illegal;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Bit positions in the 12-bit observation vector {11 controls, illegal}.
    localparam int PC = 11, LO = 10, AS = 9, EIN = 8, EALU = 7, RM = 6;
    localparam int LB = 5, LI = 4, EA = 3, EIR = 2, LA = 1, ILL = 0;

    logic [11:0] tbl [4][6];

    always #5 clk = ~clk;

    micro_instruction_decoder dut (
        .clk(clk), .rst(rst), .instr(instr), .phase(phase),
        .prog_count(prog_count), .load_out(load_out), .add_sub(add_sub),
        .enable_in(enable_in), .enable_alu(enable_alu), .read_mem(read_mem),
        .load_b(load_b), .load_instr(load_instr), .enable_a(enable_a),
        .enable_instr(enable_instr), .load_a(load_a), .illegal(illegal)
    );

    function automatic logic [11:0] observed();
        return {prog_count, load_out, add_sub, enable_in, enable_alu, read_mem,
                load_b, load_instr, enable_a, enable_instr, load_a, illegal};
    endfunction

    function automatic logic [11:0] bits(input int a, input int b = -1, input int c = -1);
        logic [11:0] w = '0;
        w[a] = 1'b1;
        if (b >= 0) w[b] = 1'b1;
        if (c >= 0) w[c] = 1'b1;
        return w;
    endfunction

    function automatic logic [11:0] model(input logic [3:0] op, input logic [3:0] ph);
        int idx = -1;
        int n = 0;
        for (int i = 0; i < 4; i++) if (ph[i]) begin n++; idx = i; end
        if (n != 1) return bits(ILL);
        if (idx >= 2 && op > 4'd5) return bits(ILL);
        if (idx < 2) return tbl[idx][0];
        return tbl[idx][op];
    endfunction

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] got = observed();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [3:0] ph, input string tag);
        @(negedge clk);
        instr = op;
        phase = ph;
        @(posedge clk);
        #1;
        check(tag, model(op, ph));
    endtask

    initial begin
        for (int p = 0; p < 4; p++) for (int o = 0; o < 6; o++) tbl[p][o] = '0;
        for (int o = 0; o < 6; o++) begin
            tbl[0][o] = bits(RM, LI);
            tbl[1][o] = bits(PC, EIR);
        end
        tbl[2][0] = bits(RM);
        tbl[2][1] = bits(LB, EIR);
        tbl[2][2] = bits(AS, LB, EIR);
        tbl[2][3] = bits(LO, EA);
        tbl[2][4] = bits(EIN, LA);
        tbl[2][5] = bits(EIR, LA);
        tbl[3][1] = bits(EALU, LA);
        tbl[3][2] = bits(EALU, AS, LA);

        instr = 4'b0001;
        phase = 4'b0100;
        #1;
        check("reset_async", '0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", '0);

`ifdef MICRO_INSTR_PHASE_GEN_EN
        @(negedge clk);
        instr = 4'b0010;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("ring_sub_%0d", k), model(4'b0010, 4'(1 << (k % 4))));
        end
        #2;
        rst = 1'b1;
        #1;
        check("ring_reset_async", '0);
        @(negedge clk);
        rst = 1'b0;
        instr = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("ring_add_%0d", k), model(4'b0001, 4'(1 << k)));
        end
`else
        @(negedge clk);
        rst = 1'b0;
        step(4'b0011, 4'b0001, "out_t0");
        check("out_t0_literal", bits(RM, LI));
        for (int o = 0; o < 6; o++) step(4'(o), 4'b0010, $sformatf("t1_op%0d", o));
        for (int o = 0; o < 6; o++) step(4'(o), 4'b0100, $sformatf("t2_op%0d", o));
        for (int o = 0; o < 6; o++) step(4'(o), 4'b1000, $sformatf("t3_op%0d", o));
        step(4'b0010, 4'b0100, "sub_t2");
        check("sub_t2_literal", bits(AS, LB, EIR));
        step(4'b0001, 4'b1000, "add_t3");
        check("add_t3_literal", bits(EALU, LA));
        step(4'b1010, 4'b0100, "undef_t2");
        check("undef_t2_literal", bits(ILL));
        step(4'b1111, 4'b1000, "undef_t3");
        step(4'b1010, 4'b0001, "undef_t0");
        step(4'b1110, 4'b0010, "undef_t1");
        step(4'b0001, 4'b0110, "phase_two_hot");
        step(4'b0001, 4'b0000, "phase_zero");
        step(4'b0001, 4'b1111, "phase_all");

        for (int k = 0; k < 80; k++) begin
            logic [3:0] op = 4'($urandom_range(0, 15));
            logic [3:0] ph = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            step(op, ph, $sformatf("rand_%0d", k));
        end

        step(4'b0010, 4'b0100, "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_mid", '0);
        @(posedge clk);
        #1;
        check("reset_hold_mid", '0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b0100, 4'b0100, "post_reset_in_t2");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
